// File: rtl/vr_stream_pkg.sv
// vr_stream_pkg: shared defaults and helpers for the valid-ready stream width converters.
//   DefaultInW   - default narrow beat width in bits
//   DefaultRatio - default number of narrow beats per wide word
//   keep_mask()  - thermometer mask with bits 0..cnt set, limited to ratio bits (up to 32)
package vr_stream_pkg;

    localparam int unsigned DefaultInW   = 8;
    localparam int unsigned DefaultRatio = 4;

    // Slice i of a completed word holds a real beat when i <= index of the completing beat.
    function automatic logic [31:0] keep_mask(input int unsigned cnt, input int unsigned ratio);
        logic [31:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i <= cnt && i < ratio) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/vr_out_reg.sv
// vr_out_reg: single-entry valid-ready holding register (data, last, optional keep).
// Optional macro VR_PACKER_KEEP_EN adds the keep_i/keep_o byte-slice mask.
// Ports:
//   clk, sync_rst         - clock, synchronous active-high reset
//   load_i                - load a new entry this edge (caller only asserts while ready_o=1)
//   data_i/last_i/keep_i  - entry contents to load
//   out_ready_i           - downstream accepts the held entry
//   valid_o/data_o/last_o/keep_o - held entry
//   ready_o               - register can take a new entry this cycle (empty or draining)
module vr_out_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned KEEP_W = 4
) (
    input  logic              clk,
    input  logic              sync_rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
`ifdef VR_PACKER_KEEP_EN
    input  logic [KEEP_W-1:0] keep_i,
    output logic [KEEP_W-1:0] keep_o,
`endif
    input  logic              out_ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              ready_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;

    assign ready_o = !valid_q || out_ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

    // A load during a drain keeps valid high; a drain alone empties the entry.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
        end else if (valid_q && out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

`ifdef VR_PACKER_KEEP_EN
    logic [KEEP_W-1:0] keep_q;

    assign keep_o = keep_q;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            keep_q <= '0;
        end else if (load_i) begin
            keep_q <= keep_i;
        end
    end
`endif

endmodule

// File: rtl/vr_word_packer.sv
// vr_word_packer: packs RATIO narrow IN_W-bit beats into one OUT_W-bit word, first beat in the
// LSBs. A beat with data_in_last closes the word early; unused upper slices are zero.
// Optional macro VR_PACKER_KEEP_EN adds data_out_keep (bit i set when slice i holds a beat).
// Ports:
//   clk, sync_rst                                  - clock, synchronous active-high reset
//   en                                             - block enable (0 stalls input side only)
//   data_in/data_in_last/data_in_valid/data_in_ready       - narrow input stream
//   data_out/data_out_last/data_out_valid/data_out_ready   - wide output stream (FIFO write side)
module vr_word_packer
    import vr_stream_pkg::*;
#(
    parameter int unsigned IN_W  = DefaultInW,
    parameter int unsigned RATIO = DefaultRatio,
    parameter int unsigned OUT_W = IN_W * RATIO,
    parameter int unsigned CNT_W = $clog2(RATIO)
) (
    input  logic             clk,
    input  logic             sync_rst,
    input  logic             en,
    input  logic [IN_W-1:0]  data_in,
    input  logic             data_in_last,
    input  logic             data_in_valid,
    output logic             data_in_ready,
    output logic [OUT_W-1:0] data_out,
    output logic             data_out_last,
    output logic             data_out_valid,
`ifdef VR_PACKER_KEEP_EN
    output logic [RATIO-1:0] data_out_keep,
`endif
    input  logic             data_out_ready
);

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [IN_W-1:0]  slot_q [RATIO-1];
    logic [IN_W-1:0]  slot_d [RATIO-1];
    logic             out_free;
    logic             in_shake;
    logic             complete;
    logic [OUT_W-1:0] word;

    assign data_in_ready = en && out_free;
    assign in_shake      = data_in_valid && data_in_ready;
    assign complete      = in_shake && (data_in_last || (beat_cnt_q == CNT_W'(RATIO - 1)));

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        slot_d     = slot_q;
        if (complete) begin
            beat_cnt_d = '0;
        end else if (in_shake) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            for (int i = 0; i < RATIO - 1; i++) begin
                if (beat_cnt_q == CNT_W'(i)) begin
                    slot_d[i] = data_in;
                end
            end
        end
    end

    // Only slots below beat_cnt are live, so stale slot contents never reach the padding.
    always_comb begin
        word = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            if (CNT_W'(i) < beat_cnt_q) begin
                word[i*IN_W +: IN_W] = slot_q[i];
            end
        end
        for (int i = 0; i < RATIO; i++) begin
            if (CNT_W'(i) == beat_cnt_q) begin
                word[i*IN_W +: IN_W] = data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            beat_cnt_q <= '0;
            for (int i = 0; i < RATIO - 1; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            beat_cnt_q <= beat_cnt_d;
            slot_q     <= slot_d;
        end
    end

`ifdef VR_PACKER_KEEP_EN
    logic [RATIO-1:0] keep_word;

    assign keep_word = RATIO'(keep_mask(32'(beat_cnt_q), RATIO));
`endif

    vr_out_reg #(
        .DATA_W (OUT_W),
        .KEEP_W (RATIO)
    ) u_out_reg (
        .clk         (clk),
        .sync_rst    (sync_rst),
        .load_i      (complete),
        .data_i      (word),
        .last_i      (data_in_last),
`ifdef VR_PACKER_KEEP_EN
        .keep_i      (keep_word),
        .keep_o      (data_out_keep),
`endif
        .out_ready_i (data_out_ready),
        .valid_o     (data_out_valid),
        .data_o      (data_out),
        .last_o      (data_out_last),
        .ready_o     (out_free)
    );

endmodule

// File: tb/tb_vr_word_packer.sv
// Directed bench for vr_word_packer (IN_W=8, RATIO=4). Inputs change 1ns after the rising
// edge; registered outputs are sampled there too, combinational ready just before the edge.
module tb_vr_word_packer;

    logic        clk = 1'b0;
    logic        sync_rst;
    logic        en;
    logic [7:0]  data_in;
    logic        data_in_last;
    logic        data_in_valid;
    logic        data_in_ready;
    logic [31:0] data_out;
    logic        data_out_last;
    logic        data_out_valid;
    logic        data_out_ready;
`ifdef VR_PACKER_KEEP_EN
    logic [3:0]  data_out_keep;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vr_word_packer #(
        .IN_W  (8),
        .RATIO (4)
    ) dut (
        .clk            (clk),
        .sync_rst       (sync_rst),
        .en             (en),
        .data_in        (data_in),
        .data_in_last   (data_in_last),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_last  (data_out_last),
        .data_out_valid (data_out_valid),
`ifdef VR_PACKER_KEEP_EN
        .data_out_keep  (data_out_keep),
`endif
        .data_out_ready (data_out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, require ready, take the edge, then drop valid.
    task automatic send(input logic [7:0] d, input logic l, input string tag);
        data_in       = d;
        data_in_last  = l;
        data_in_valid = 1'b1;
        #1;
        chk(tag, {31'd0, data_in_ready}, 32'd1);
        tick();
        data_in_valid = 1'b0;
        data_in_last  = 1'b0;
    endtask

    task automatic chk_word(input string tag, input logic [31:0] w, input logic l,
                            input logic [3:0] k);
        chk({tag, ".valid"}, {31'd0, data_out_valid}, 32'd1);
        chk({tag, ".data"}, data_out, w);
        chk({tag, ".last"}, {31'd0, data_out_last}, {31'd0, l});
`ifdef VR_PACKER_KEEP_EN
        chk({tag, ".keep"}, {28'd0, data_out_keep}, {28'd0, k});
`else
        if (k == 4'hx) $display("unused keep");
`endif
    endtask

    initial begin
        sync_rst       = 1'b1;
        en             = 1'b1;
        data_in        = 8'h00;
        data_in_last   = 1'b0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        tick();
        tick();
        chk("rst.valid", {31'd0, data_out_valid}, 32'd0);
        chk("rst.data", data_out, 32'd0);
        chk("rst.last", {31'd0, data_out_last}, 32'd0);
`ifdef VR_PACKER_KEEP_EN
        chk("rst.keep", {28'd0, data_out_keep}, 32'd0);
`endif
        sync_rst = 1'b0;

        // Full packet with last on the fourth beat.
        send(8'h11, 1'b0, "t1.rdy0");
        chk("t1.notyet", {31'd0, data_out_valid}, 32'd0);
        send(8'h22, 1'b0, "t1.rdy1");
        send(8'h33, 1'b0, "t1.rdy2");
        send(8'h44, 1'b1, "t1.rdy3");
        chk_word("t1", 32'h44332211, 1'b1, 4'b1111);
        tick();
        chk("t1.drain", {31'd0, data_out_valid}, 32'd0);

        // Short packet padded with zeros, then a full word with no stale bytes.
        send(8'hAA, 1'b0, "t2.rdy0");
        send(8'hBB, 1'b1, "t2.rdy1");
        chk_word("t2.short", 32'h0000BBAA, 1'b1, 4'b0011);
        send(8'h01, 1'b0, "t2.rdy2");
        chk("t2.drain", {31'd0, data_out_valid}, 32'd0);
        send(8'h02, 1'b0, "t2.rdy3");
        send(8'h03, 1'b0, "t2.rdy4");
        send(8'h04, 1'b1, "t2.rdy5");
        chk_word("t2.full", 32'h04030201, 1'b1, 4'b1111);
        tick();

        // Eight back-to-back beats with no last.
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), 1'b0, "t3.rdy");
            if (i == 4) chk_word("t3.w0", 32'h04030201, 1'b0, 4'b1111);
            if (i == 5) chk("t3.gap", {31'd0, data_out_valid}, 32'd0);
        end
        chk_word("t3.w1", 32'h08070605, 1'b0, 4'b1111);
        tick();

        // Backpressure: pending word holds, input stalls, beat accepted on the drain edge.
        send(8'h11, 1'b0, "t4.rdy0");
        send(8'h22, 1'b0, "t4.rdy1");
        send(8'h33, 1'b0, "t4.rdy2");
        data_out_ready = 1'b0;
        send(8'h44, 1'b1, "t4.rdy3");
        tick();
        chk_word("t4.hold", 32'h44332211, 1'b1, 4'b1111);
        data_in       = 8'h55;
        data_in_last  = 1'b1;
        data_in_valid = 1'b1;
        #1;
        chk("t4.stall", {31'd0, data_in_ready}, 32'd0);
        tick();
        chk_word("t4.hold2", 32'h44332211, 1'b1, 4'b1111);
        data_out_ready = 1'b1;
        #1;
        chk("t4.release", {31'd0, data_in_ready}, 32'd1);
        tick();
        data_in_valid = 1'b0;
        data_in_last  = 1'b0;
        chk_word("t4.reload", 32'h00000055, 1'b1, 4'b0001);
        tick();
        chk("t4.drain", {31'd0, data_out_valid}, 32'd0);

        // Mid-packet reset discards the partial word.
        send(8'h11, 1'b0, "t5.rdy0");
        send(8'h22, 1'b0, "t5.rdy1");
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        chk("t5.valid", {31'd0, data_out_valid}, 32'd0);
        chk("t5.data", data_out, 32'd0);
        send(8'h33, 1'b0, "t5.rdy2");
        send(8'h44, 1'b0, "t5.rdy3");
        send(8'h55, 1'b0, "t5.rdy4");
        send(8'h66, 1'b1, "t5.rdy5");
        chk_word("t5", 32'h66554433, 1'b1, 4'b1111);
        tick();

        // Enable dropped mid-packet: offered beats are refused and the accumulator holds.
        send(8'h11, 1'b0, "t6.rdy0");
        en            = 1'b0;
        data_in       = 8'hEE;
        data_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t6.off", {31'd0, data_in_ready}, 32'd0);
            tick();
        end
        data_in_valid = 1'b0;
        en            = 1'b1;
        send(8'h22, 1'b0, "t6.rdy1");
        send(8'h33, 1'b0, "t6.rdy2");
        data_out_ready = 1'b0;
        send(8'h44, 1'b1, "t6.rdy3");
        chk_word("t6", 32'h44332211, 1'b1, 4'b1111);

        // A held word still drains while disabled.
        en = 1'b0;
        tick();
        chk("t6.held", {31'd0, data_out_valid}, 32'd1);
        data_out_ready = 1'b1;
        tick();
        chk("t6.drain", {31'd0, data_out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
